adc_spi_arbiter: RTL

Shared SPI transaction engine and round-robin arbiter for the three ADC3241 configuration ports. Up to three requesters (power-up init sequencer, host register bridge, periodic health readback) issue single-register write or read transactions. The block serialises them onto one spi_sclk/spi_mosi/spi_miso bus with per-device chip selects. It is the only driver of the ADC SPI pins once integrated.

---
 rtl/adc_spi_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_arbiter.sv
// Round-robin SPI transaction engine for the three ADC3241 config ports.
// One 24-bit frame per grant: {rw, fix, addr[13:0], data[7:0]}, MSB first.
module adc_spi_arbiter #(
  parameter int SCK_HALF = 2,
  parameter int GAP_CYC  = 10,
  parameter bit FIX_BIT  = 1'b1
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rw,
  input  logic [5:0]  req_dev,
  input  logic [41:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_sclk,
  output logic [2:0]  spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic [4:0] HALF_END = 5'(SCK_HALF - 1);
  localparam logic [4:0] PER_END  = 5'(2 * SCK_HALF - 1);
  localparam logic [7:0] GAP_END  = 8'(GAP_CYC - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  cur_w;
  logic [1:0]  cur_dev;
  logic        cur_rw;
  logic [23:0] frame_sr;
  logic [4:0]  ph_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  cap;

  logic [1:0]  o0, o1, o2;
  logic [1:0]  win;
  logic [1:0]  win_nxt;
  logic        w_rw;
  logic [1:0]  w_dev;
  logic [13:0] w_addr;
  logic [7:0]  w_wdata;
  logic [23:0] w_frame;

  // Search order starts at rr_ptr and wraps modulo 3.
  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    case (rr_ptr)
      2'd1: begin
        o0 = 2'd1;
        o1 = 2'd2;
        o2 = 2'd0;
      end
      2'd2: begin
        o0 = 2'd2;
        o1 = 2'd0;
        o2 = 2'd1;
      end
      default: begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
      end
    endcase
    if (req[o0])
      win = o0;
    else if (req[o1])
      win = o1;
    else
      win = o2;
    win_nxt = (win == 2'd2) ? 2'd0 : win + 2'd1;
  end

  always_comb begin
    w_rw    = req_rw[0];
    w_dev   = req_dev[1:0];
    w_addr  = req_addr[13:0];
    w_wdata = req_wdata[7:0];
    unique case (1'b1)
      (win == 2'd1): begin
        w_rw    = req_rw[1];
        w_dev   = req_dev[3:2];
        w_addr  = req_addr[27:14];
        w_wdata = req_wdata[15:8];
      end
      (win == 2'd2): begin
        w_rw    = req_rw[2];
        w_dev   = req_dev[5:4];
        w_addr  = req_addr[41:28];
        w_wdata = req_wdata[23:16];
      end
      default: begin
        w_rw    = req_rw[0];
        w_dev   = req_dev[1:0];
        w_addr  = req_addr[13:0];
        w_wdata = req_wdata[7:0];
      end
    endcase
    w_frame = {w_rw, FIX_BIT, w_addr,
               w_rw ? 8'h00 : w_wdata};
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      cur_w    <= 2'd0;
      cur_dev  <= 2'd0;
      cur_rw   <= 1'b0;
      frame_sr <= '0;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      cap      <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_cs   <= 3'b111;
      spi_mosi <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            frame_sr <= {w_frame[22:0], 1'b0};
            spi_mosi <= w_frame[23];
            gnt      <= 3'b001 << win;
            rr_ptr   <= win_nxt;
            cur_w    <= win;
            cur_dev  <= w_dev;
            cur_rw   <= w_rw;
            spi_cs   <= (w_dev == 2'd3) ? 3'b111
                                        : ~(3'b001 << w_dev);
            ph_cnt   <= '0;
            bit_cnt  <= 5'd23;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ph_cnt == PER_END) begin
            // Period end doubles as the falling edge: sample MISO here.
            ph_cnt   <= '0;
            spi_sclk <= 1'b0;
            cap      <= {cap[6:0], spi_miso};
            if (bit_cnt == 5'd0) begin
              spi_cs   <= 3'b111;
              spi_mosi <= 1'b0;
              done     <= 3'b001 << cur_w;
              err      <= (cur_dev == 2'd3);
              if (cur_rw)
                rdata <= {cap[6:0], spi_miso};
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              bit_cnt  <= bit_cnt - 5'd1;
              spi_mosi <= frame_sr[23];
              frame_sr <= {frame_sr[22:0], 1'b0};
            end
          end else begin
            ph_cnt <= ph_cnt + 5'd1;
            if (ph_cnt == HALF_END)
              spi_sclk <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
